ahb_lite_arbiter_ctrl: RTL

Parametrised bus arbiter and transfer controller for the shared master/slave interconnect. It replaces the fixed two-master, two-slave control FSM. It arbitrates NUM_MASTERS requesters round-robin, decodes the target slave, and sequences address and data phases. It handles slave RETRY/SPLIT/ERROR responses and aborts stalled transfers on timeout. Its outputs drive the master-side address/data muxes and the slave select lines.

---
 rtl/ahb_lite_arbiter_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_arbiter_ctrl.sv
// Round-robin bus arbiter and address/data phase sequencer for the shared interconnect.
// Handles slave RETRY/SPLIT/ERROR responses and aborts stalled data phases on timeout.
`timescale 1ns/1ps
module ahb_lite_arbiter_ctrl #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3,
  localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    busreq,
  input  logic [NUM_MASTERS*SW-1:0] req_slv,
  input  logic [NUM_MASTERS-1:0]    req_wr,
  input  logic                      ready,
  input  logic [1:0]                response,
  input  logic [NUM_MASTERS-1:0]    split_release,
  output logic [NUM_MASTERS-1:0]    grant,
  output logic [MW-1:0]             mst_sel,
  output logic [NUM_SLAVES-1:0]     slv_sel,
  output logic                      aout,
  output logic                      dout,
  output logic                      txn_done,
  output logic                      txn_err,
  output logic [NUM_MASTERS-1:0]    split_mask
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state, state_nxt;
  logic [MW-1:0]          cur_m, last_grant, arb_m;
  logic [SW-1:0]          cur_slv;
  logic                   cur_wr;
  logic [TW-1:0]          wait_cnt;
  logic [RW-1:0]          retry_cnt;
  logic [NUM_MASTERS-1:0] eligible, cur_onehot;
  logic                   arb_hit, slv_bad, xfer_end, done_nxt, err_nxt;
  logic                   split_set, retry_inc, wait_inc;
  int unsigned            cand;

  // Search starts one past the last granted master and wraps.
  always_comb begin
    eligible = busreq & ~split_mask;
    arb_hit  = 1'b0;
    arb_m    = '0;
    cand     = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = (32'(last_grant) + i) % NUM_MASTERS;
      if (!arb_hit && eligible[cand[MW-1:0]]) begin
        arb_hit = 1'b1;
        arb_m   = cand[MW-1:0];
      end
    end
  end

  always_comb begin
    slv_bad   = ({1'b0, cur_slv} >= (SW+1)'(NUM_SLAVES));
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    xfer_end  = 1'b0;
    split_set = 1'b0;
    retry_inc = 1'b0;
    wait_inc  = 1'b0;
    case (state)
      IDLE: if (arb_hit) state_nxt = ADDR;
      ADDR: begin
        if (slv_bad) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          xfer_end  = 1'b1;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (ready) begin
          case (response)
            2'b00: begin
              state_nxt = IDLE; done_nxt = 1'b1; xfer_end = 1'b1;
            end
            2'b01: begin
              state_nxt = IDLE; done_nxt = 1'b1; err_nxt = 1'b1; xfer_end = 1'b1;
            end
            2'b10: begin
              if (retry_cnt == RW'(MAX_RETRY)) begin
                state_nxt = IDLE; err_nxt = 1'b1; xfer_end = 1'b1;
              end else begin
                state_nxt = ADDR; retry_inc = 1'b1;
              end
            end
            default: begin
              state_nxt = IDLE; split_set = 1'b1; xfer_end = 1'b1;
            end
          endcase
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE; err_nxt = 1'b1; xfer_end = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_onehot        = '0;
    cur_onehot[cur_m] = 1'b1;
    grant   = '0;
    mst_sel = '0;
    slv_sel = '0;
    aout    = (state == ADDR);
    dout    = (state == DATA) && cur_wr;
    if (state != IDLE) begin
      grant   = cur_onehot;
      mst_sel = cur_m;
      for (int unsigned s = 0; s < NUM_SLAVES; s++) slv_sel[s] = (cur_slv == SW'(s));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur_m      <= '0;
      last_grant <= MW'(NUM_MASTERS - 1);
      cur_slv    <= '0;
      cur_wr     <= 1'b0;
      wait_cnt   <= '0;
      retry_cnt  <= '0;
      split_mask <= '0;
      txn_done   <= 1'b0;
      txn_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      txn_done <= done_nxt;
      txn_err  <= err_nxt;
      // A same-cycle SPLIT on a released master keeps it parked.
      split_mask <= (split_mask & ~split_release) | (split_set ? cur_onehot : '0);
      if (state == IDLE && arb_hit) begin
        cur_m     <= arb_m;
        cur_slv   <= req_slv[arb_m*SW +: SW];
        cur_wr    <= req_wr[arb_m];
        wait_cnt  <= '0;
        retry_cnt <= '0;
      end
      if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
        wait_cnt  <= '0;
      end
      if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (xfer_end) last_grant <= cur_m;
    end
  end

endmodule
